// File: rtl/mul_arbiter.sv
// Two-port round-robin arbiter sharing one registered unsigned N x N multiplier.
// One operation in flight: accept operands (IDLE), multiply (CALC), hold the result (RESP).
module mul_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [2*N-1:0] resp_y
);

    localparam int unsigned YW = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            grant, grant_nxt;
    logic            prio, prio_nxt;
    logic [N-1:0]    op_a, op_a_nxt;
    logic [N-1:0]    op_b, op_b_nxt;
    logic [YW-1:0]   res, res_nxt;
    logic            sel;

    // State and datapath registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            grant <= 1'b0;
            prio  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            prio  <= prio_nxt;
            op_a  <= op_a_nxt;
            op_b  <= op_b_nxt;
            res   <= res_nxt;
        end
    end

    // Next state, arbitration and output decode
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        prio_nxt    = prio;
        op_a_nxt    = op_a;
        op_b_nxt    = op_b;
        res_nxt     = res;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        resp_y      = '0;
        // Port 1 wins when it is the only requester or when it holds priority
        sel         = req1_valid && (!req0_valid || prio);

        case (state)
            IDLE: begin
                req0_ready = req0_valid && !sel;
                req1_ready = req1_valid && sel;
                if (req0_ready || req1_ready) begin
                    state_nxt = CALC;
                    grant_nxt = sel;
                    op_a_nxt  = sel ? req1_a : req0_a;
                    op_b_nxt  = sel ? req1_b : req0_b;
                end
            end
            CALC: begin
                res_nxt   = YW'(op_a) * YW'(op_b);
                state_nxt = RESP;
            end
            RESP: begin
                resp0_valid = !grant;
                resp1_valid = grant;
                resp_y      = res;
                if (grant ? resp1_ready : resp0_ready) begin
                    prio_nxt  = !grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: scenario tasks with an expected-result queue.
module tb_mul_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned YW = 2 * N;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [YW-1:0] resp_y;

    typedef struct packed {
        logic          port;
        logic [YW-1:0] y;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    mul_arbiter #(.N(N)) dut (
        .clk(clk), .n_reset(n_reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_y(resp_y)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are observed on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    function automatic logic [YW-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        return YW'(a) * YW'(b);
    endfunction

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        look();
        n_vec++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_y} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got r=%b%b v=%b%b y=%0d, expected all 0",
                     req0_ready, req1_ready, resp0_valid, resp1_valid, resp_y);
        end
        tick();
        n_reset = 1'b1;
        look();
        n_vec++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_y} !== '0) begin
            n_err++;
            $display("FAIL reset_release: got r=%b%b v=%b%b y=%0d, expected all 0",
                     req0_ready, req1_ready, resp0_valid, resp1_valid, resp_y);
        end
    endtask

    task automatic test_zero();
        sb.delete();
        tick();
        req0_a = '0; req0_b = '0; req0_valid = 1'b1; resp0_ready = 1'b1;
        sb.push_back('{1'b0, prod(4'd0, 4'd0)});
        look();
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL t1_accept: got req0_ready=%b, expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        look();
        n_vec++;
        if (resp0_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t1_early: got resp0_valid=%b one cycle after accept, expected 0", resp0_valid);
        end
        tick();
        look();
        e = sb.pop_front();
        n_vec++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_y !== e.y) begin
            n_err++;
            $display("FAIL t1_latency: got v=%b%b y=%0d, expected v=01 y=%0d",
                     resp1_valid, resp0_valid, resp_y, e.y);
        end
        tick();
        look();
        n_vec++;
        if (resp0_valid !== 1'b0 || resp_y !== '0) begin
            n_err++;
            $display("FAIL t1_done: got resp0_valid=%b y=%0d, expected 0 0", resp0_valid, resp_y);
        end
        resp0_ready = 1'b0;
    endtask

    task automatic test_max();
        sb.delete();
        for (int p = 0; p < 2; p++) begin
            tick();
            resp0_ready = 1'b1; resp1_ready = 1'b1;
            if (p == 0) begin
                req0_a = 4'd15; req0_b = 4'd15; req0_valid = 1'b1;
            end else begin
                req1_a = 4'd15; req1_b = 4'd15; req1_valid = 1'b1;
            end
            sb.push_back('{(p == 1), prod(4'd15, 4'd15)});
            look();
            n_vec++;
            if ({req1_ready, req0_ready} !== ((p == 1) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL t2_ready_p%0d: got ready=%b%b, expected single ready on port %0d",
                         p, req1_ready, req0_ready, p);
            end
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            look();
            for (int i = 0; i < 8 && !(resp0_valid || resp1_valid); i++) begin
                tick();
                look();
            end
            e = sb.pop_front();
            n_vec++;
            if ({resp1_valid, resp0_valid} !== (e.port ? 2'b10 : 2'b01) || resp_y !== e.y) begin
                n_err++;
                $display("FAIL t2_result_p%0d: got v=%b%b y=%0d, expected port %0d y=%0d",
                         p, resp1_valid, resp0_valid, resp_y, e.port, e.y);
            end
            tick();
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic test_priority();
        sb.delete();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        req0_a = 4'd7; req0_b = 4'd9; req1_a = 4'd3; req1_b = 4'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        sb.push_back('{1'b0, 8'd63});
        sb.push_back('{1'b1, 8'd15});
        look();
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL t3_first_grant: got ready=%b%b, expected 01", req1_ready, req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        tick();
        look();
        e = sb.pop_front();
        n_vec++;
        if ({resp1_valid, resp0_valid} !== 2'b01 || resp_y !== e.y) begin
            n_err++;
            $display("FAIL t3_port0: got v=%b%b y=%0d, expected v=01 y=%0d",
                     resp1_valid, resp0_valid, resp_y, e.y);
        end
        tick();
        look();
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL t3_second_grant: got ready=%b%b, expected 10", req1_ready, req0_ready);
        end
        tick();
        req1_valid = 1'b0;
        tick();
        look();
        e = sb.pop_front();
        n_vec++;
        if ({resp1_valid, resp0_valid} !== 2'b10 || resp_y !== e.y) begin
            n_err++;
            $display("FAIL t3_port1: got v=%b%b y=%0d, expected v=10 y=%0d",
                     resp1_valid, resp0_valid, resp_y, e.y);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] a0[3], b0[3], a1[3], b1[3];
        int idx0, idx1, got, cyc;
        logic acc0, acc1;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            a0[k] = N'($urandom_range(15)); b0[k] = N'($urandom_range(15));
            a1[k] = N'($urandom_range(15)); b1[k] = N'($urandom_range(15));
        end
        for (int i = 0; i < 6; i++)
            sb.push_back((i % 2 == 0) ? '{1'b0, prod(a0[i/2], b0[i/2])}
                                      : '{1'b1, prod(a1[i/2], b1[i/2])});
        idx0 = 0; idx1 = 0; got = 0; cyc = 0;
        tick();
        req0_a = a0[0]; req0_b = b0[0]; req1_a = a1[0]; req1_b = b1[0];
        req0_valid = 1'b1; req1_valid = 1'b1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        while (got < 6 && cyc < 100) begin
            look();
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            n_vec++;
            if (acc0 && acc1) begin
                n_err++;
                $display("FAIL t4_one_ready: got both ready in cycle %0d, expected at most one", cyc);
            end
            if (resp0_valid || resp1_valid) begin
                e = sb.pop_front();
                n_vec++;
                if ({resp1_valid, resp0_valid} !== (e.port ? 2'b10 : 2'b01) || resp_y !== e.y) begin
                    n_err++;
                    $display("FAIL t4_op%0d: got v=%b%b y=%0d, expected port %0d y=%0d",
                             got, resp1_valid, resp0_valid, resp_y, e.port, e.y);
                end
                got++;
            end
            tick();
            if (acc0) begin
                idx0++;
                if (idx0 < 3) begin req0_a = a0[idx0]; req0_b = b0[idx0]; end
                else req0_valid = 1'b0;
            end
            if (acc1) begin
                idx1++;
                if (idx1 < 3) begin req1_a = a1[idx1]; req1_b = b1[idx1]; end
                else req1_valid = 1'b0;
            end
            cyc++;
        end
        n_vec++;
        if (got != 6) begin
            n_err++;
            $display("FAIL t4_timeout: got %0d results, expected 6", got);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        sb.delete();
        tick();
        req1_a = 4'd12; req1_b = 4'd11; req1_valid = 1'b1; resp1_ready = 1'b0;
        sb.push_back('{1'b1, 8'd132});
        look();
        n_vec++;
        if (req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL t5_accept: got req1_ready=%b, expected 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        req0_a = 4'd1; req0_b = 4'd1; req0_valid = 1'b1;
        look();
        for (int i = 0; i < 8 && !resp1_valid; i++) begin
            tick();
            look();
        end
        e = sb.pop_front();
        for (int w = 0; w < 4; w++) begin
            n_vec++;
            if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_y !== e.y
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL t5_hold_%0d: got v=%b%b y=%0d r=%b%b, expected v=10 y=%0d r=00",
                         w, resp1_valid, resp0_valid, resp_y, req1_ready, req0_ready, e.y);
            end
            tick();
            if (w == 3) begin
                resp1_ready = 1'b1;
                req0_valid  = 1'b0;
            end
            look();
        end
        n_vec++;
        if (resp1_valid !== 1'b1 || resp_y !== e.y) begin
            n_err++;
            $display("FAIL t5_release: got v=%b y=%0d, expected v=1 y=%0d", resp1_valid, resp_y, e.y);
        end
        tick();
        look();
        n_vec++;
        if (resp1_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t5_complete: got resp1_valid=%b after ready, expected 0", resp1_valid);
        end
        resp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        sb.delete();
        tick();
        req0_a = 4'd5; req0_b = 4'd5; req0_valid = 1'b1; resp0_ready = 1'b1;
        look();
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL t6_accept: got req0_ready=%b, expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1 n_reset = 1'b0;
        look();
        n_vec++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_y} !== '0) begin
            n_err++;
            $display("FAIL t6_in_reset: got v=%b%b y=%0d, expected all 0", resp1_valid, resp0_valid, resp_y);
        end
        tick();
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            look();
            n_vec++;
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp_y !== '0) begin
                n_err++;
                $display("FAIL t6_discard_%0d: got v=%b%b y=%0d, expected 00 0",
                         i, resp1_valid, resp0_valid, resp_y);
            end
            tick();
        end
        req1_a = 4'd2; req1_b = 4'd3; req1_valid = 1'b1; resp1_ready = 1'b1;
        sb.push_back('{1'b1, 8'd6});
        look();
        tick();
        req1_valid = 1'b0;
        look();
        for (int i = 0; i < 8 && !(resp0_valid || resp1_valid); i++) begin
            tick();
            look();
        end
        e = sb.pop_front();
        n_vec++;
        if ({resp1_valid, resp0_valid} !== 2'b10 || resp_y !== e.y) begin
            n_err++;
            $display("FAIL t6_after: got v=%b%b y=%0d, expected v=10 y=%0d",
                     resp1_valid, resp0_valid, resp_y, e.y);
        end
        tick();
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    initial begin
        n_reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        test_reset();
        test_zero();
        test_max();
        test_priority();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
